// File: rtl/hex_digits_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hex_digits_scan_ctrl
// Description : Scans a 4-digit seven-segment display from a 16-bit hex value.
//               It snapshots the value once per frame, suppresses leading
//               zeros, and inserts an all-off guard interval at each digit
//               slot. Optional digit blinking is enabled by HEX_SCAN_BLINK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_digits_scan_ctrl #(
  parameter int DIV   = 50000,
  parameter int GUARD = 500
`ifdef HEX_SCAN_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        freeze,
  input  logic        lz_en,
`ifdef HEX_SCAN_BLINK_EN
  input  logic [3:0]  blink_mask,
`endif
  output logic [6:0]  seg_n,
  output logic [3:0]  dig_sel_n,
  output logic        frame_done
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] C_CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [6:0]    seg_n_q, seg_n_d;
  logic [3:0]    dig_sel_n_q, dig_sel_n_d;
  logic          frame_done_q, frame_done_d;

  logic          tick, wrap, in_guard, blank, dark;
  logic [3:0]    nib;
  logic [6:0]    seg_dec;

  assign tick = (cnt_q == C_CNT_MAX);
  assign wrap = tick && (idx_q == 2'd3);

  generate
    if (GUARD == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      localparam logic [CW-1:0] C_GUARD = CW'(GUARD);
      assign in_guard = (cnt_q < C_GUARD);
    end
  endgenerate

`ifdef HEX_SCAN_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] C_FRAME_MAX = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blink_phase_q, blink_phase_d;

  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (wrap) begin
      if (frame_cnt_q == C_FRAME_MAX) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // Mask is read live so blinking can be changed without waiting for a frame.
  assign dark = blink_phase_q && blink_mask[idx_q];
`else
  assign dark = 1'b0;
`endif

  always_comb begin
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    idx_d        = tick ? idx_q + 2'd1 : idx_q;
    shadow_d     = (wrap && !freeze) ? value : shadow_q;
    frame_done_d = wrap;

    nib = shadow_q[{idx_q, 2'b00} +: 4];

    // Digit k is a leading zero when every nibble from k upward is zero.
    blank = 1'b0;
    case (idx_q)
      2'd1:    blank = lz_en && (shadow_q[15:4]  == 12'h000);
      2'd2:    blank = lz_en && (shadow_q[15:8]  == 8'h00);
      2'd3:    blank = lz_en && (shadow_q[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase

    case (nib)
      4'h0:    seg_dec = 7'h40;
      4'h1:    seg_dec = 7'h79;
      4'h2:    seg_dec = 7'h24;
      4'h3:    seg_dec = 7'h30;
      4'h4:    seg_dec = 7'h19;
      4'h5:    seg_dec = 7'h12;
      4'h6:    seg_dec = 7'h02;
      4'h7:    seg_dec = 7'h78;
      4'h8:    seg_dec = 7'h00;
      4'h9:    seg_dec = 7'h10;
      4'hA:    seg_dec = 7'h08;
      4'hB:    seg_dec = 7'h03;
      4'hC:    seg_dec = 7'h46;
      4'hD:    seg_dec = 7'h21;
      4'hE:    seg_dec = 7'h06;
      default: seg_dec = 7'h0E;
    endcase

    if (in_guard) begin
      dig_sel_n_d = 4'hF;
      seg_n_d     = 7'h7F;
    end else begin
      dig_sel_n_d = 4'hF ^ (4'b0001 << idx_q);
      seg_n_d     = (blank || dark) ? 7'h7F : seg_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      shadow_q     <= 16'h0000;
      seg_n_q      <= 7'h7F;
      dig_sel_n_q  <= 4'hF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      seg_n_q      <= seg_n_d;
      dig_sel_n_q  <= dig_sel_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_n      = seg_n_q;
  assign dig_sel_n  = dig_sel_n_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_digits_scan_ctrl.sv
`default_nettype none
// Testbench for hex_digits_scan_ctrl: frame-level vector table plus directed
// sequences (tearing/freeze, mid-slot reset, zero-guard instance, blinking).
module tb_hex_digits_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        freeze;
  logic        lz_en;
  logic [3:0]  blink_mask;
  logic [6:0]  seg_n, seg1_n;
  logic [3:0]  dig_sel_n, dig_sel1_n;
  logic        frame_done, frame_done1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hex_digits_scan_ctrl #(
    .DIV(4), .GUARD(1)
`ifdef HEX_SCAN_BLINK_EN
    , .BLINK_FRAMES(2)
`endif
  ) u0 (
    .clk(clk), .reset(reset), .value(value), .freeze(freeze), .lz_en(lz_en),
`ifdef HEX_SCAN_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .seg_n(seg_n), .dig_sel_n(dig_sel_n), .frame_done(frame_done)
  );

  hex_digits_scan_ctrl #(
    .DIV(2), .GUARD(0)
`ifdef HEX_SCAN_BLINK_EN
    , .BLINK_FRAMES(2)
`endif
  ) u1 (
    .clk(clk), .reset(reset), .value(value), .freeze(freeze), .lz_en(lz_en),
`ifdef HEX_SCAN_BLINK_EN
    .blink_mask(4'b0000),
`endif
    .seg_n(seg1_n), .dig_sel_n(dig_sel1_n), .frame_done(frame_done1)
  );

  typedef struct {
    logic [15:0] val;
    logic        lz;
    logic [27:0] segs;  // {d3,d2,d1,d0}
  } vec_t;

  vec_t vecs[9];

  localparam logic [27:0] ZEROS   = {7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [27:0] ZERO_LZ = {7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [27:0] ONES    = {7'h79, 7'h79, 7'h79, 7'h79};
  localparam logic [27:0] TWOS    = {7'h24, 7'h24, 7'h24, 7'h24};
  localparam logic [27:0] S12AF   = {7'h79, 7'h24, 7'h08, 7'h0E};

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Checks edges first..last of a 16-cycle frame on the DIV=4/GUARD=1 instance.
  task automatic run_main(input logic [27:0] segs, input int first, input int last);
    for (int j = first; j <= last; j++) begin
      int         slot;
      logic [3:0] es;
      slot = (j - 1) / 4;
      es   = 4'hF ^ (4'b0001 << slot);
      step();
      if (((j - 1) % 4) == 0) begin
        chk("guard_sel", dig_sel_n, 4'hF);
        chk("guard_seg", seg_n, 7'h7F);
      end else begin
        chk("dig_sel", dig_sel_n, es);
        chk("seg", seg_n, segs[slot*7 +: 7]);
      end
      chk("frame_done", frame_done, (j == 16));
    end
  endtask

  initial begin
    vecs[0] = '{16'h12AF, 1'b0, S12AF};
    vecs[1] = '{16'h0050, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}};
    vecs[2] = '{16'h0000, 1'b1, ZERO_LZ};
    vecs[3] = '{16'h0000, 1'b0, ZEROS};
    vecs[4] = '{16'h8000, 1'b1, {7'h00, 7'h40, 7'h40, 7'h40}};
    vecs[5] = '{16'h0001, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h79}};
    vecs[6] = '{16'hFEDC, 1'b0, {7'h0E, 7'h06, 7'h21, 7'h46}};
    vecs[7] = '{16'h0B07, 1'b1, {7'h7F, 7'h03, 7'h40, 7'h78}};
    vecs[8] = '{16'h9690, 1'b0, {7'h10, 7'h02, 7'h10, 7'h40}};

    reset = 1'b1; value = 16'h12AF; freeze = 1'b0; lz_en = 1'b0; blink_mask = 4'b0000;
    step();
    step();
    chk("rst_sel", dig_sel_n, 4'hF);
    chk("rst_seg", seg_n, 7'h7F);
    chk("rst_fd", frame_done, 1'b0);
    chk("rst_sel1", dig_sel1_n, 4'hF);
    chk("rst_seg1", seg1_n, 7'h7F);

    // Zero-guard instance: every cycle drives a digit, 8-cycle frames.
    reset = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      int          slot;
      logic [27:0] s;
      slot = ((j - 1) / 2) % 4;
      s    = (j <= 8) ? ZEROS : S12AF;
      step();
      chk("g0_sel", dig_sel1_n, 4'hF ^ (4'b0001 << slot));
      chk("g0_seg", seg1_n, s[slot*7 +: 7]);
      chk("g0_fd", frame_done1, (j == 8) || (j == 16));
    end

    // Table: first frame shows the reset shadow, second the snapshot.
    for (int v = 0; v < 9; v++) begin
      value = vecs[v].val;
      lz_en = vecs[v].lz;
      do_reset();
      run_main(vecs[v].lz ? ZERO_LZ : ZEROS, 1, 16);
      run_main(vecs[v].segs, 1, 16);
    end

    // No tearing mid-frame, then freeze holds the snapshot.
    value = 16'h1111; lz_en = 1'b0; freeze = 1'b0;
    do_reset();
    run_main(ZEROS, 1, 16);
    run_main(ONES, 1, 8);
    value = 16'h2222;
    run_main(ONES, 9, 16);
    run_main(TWOS, 1, 16);
    value  = 16'h1111;
    freeze = 1'b1;
    run_main(TWOS, 1, 16);
    run_main(TWOS, 1, 16);
    freeze = 1'b0;
    run_main(TWOS, 1, 16);
    run_main(ONES, 1, 16);

    // Reset asserted for one cycle in the middle of slot 2.
    value = 16'h0050; lz_en = 1'b0;
    do_reset();
    run_main(ZEROS, 1, 16);
    run_main({7'h40, 7'h40, 7'h12, 7'h40}, 1, 10);
    reset = 1'b1;
    step();
    chk("mid_rst_sel", dig_sel_n, 4'hF);
    chk("mid_rst_seg", seg_n, 7'h7F);
    chk("mid_rst_fd", frame_done, 1'b0);
    reset = 1'b0;
    run_main(ZEROS, 1, 16);
    run_main({7'h40, 7'h40, 7'h12, 7'h40}, 1, 16);

`ifdef HEX_SCAN_BLINK_EN
    // Digit 0 dark in frames 2-3, lit again in frame 4.
    value = 16'h12AF; lz_en = 1'b0; blink_mask = 4'b0001;
    do_reset();
    run_main(ZEROS, 1, 16);
    run_main(S12AF, 1, 16);
    run_main({S12AF[27:7], 7'h7F}, 1, 16);
    run_main({S12AF[27:7], 7'h7F}, 1, 16);
    run_main(S12AF, 1, 16);
    run_main(S12AF, 1, 16);
    run_main({S12AF[27:7], 7'h7F}, 1, 16);
    blink_mask = 4'b0000;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
